// File: rtl/boolean_lut_sweep.sv
// Programmable N_IN-input / N_OUT-output boolean LUT with a registered evaluate
// path and a built-in exhaustive sweep that folds every table word into a checksum.
module boolean_lut_sweep #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int CSUM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [N_IN-1:0]   cfg_addr,
  input  logic [N_OUT-1:0]  cfg_data,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_data,
  input  logic              start,
  output logic              out_valid,
  output logic [N_IN-1:0]   out_addr,
  output logic [N_OUT-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] csum
);
  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                        state, state_nxt;
  logic [N_IN-1:0]               cnt;
  logic [DEPTH-1:0][N_OUT-1:0]   tbl;
  logic                          busy_d, done_d;
  logic                          tbl_we;

  // Table is frozen outside IDLE so a sweep always sees a consistent function.
  assign tbl_we = cfg_we && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tbl <= '0;
    else if (tbl_we) tbl[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (cnt == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are registered one cycle behind the state so done lines up with the
  // cycle after the last sweep word is presented.
  always_comb begin
    busy_d = (state_nxt != IDLE) || (state == DONE);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      csum      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            csum      <= '0;
            out_valid <= 1'b0;
          end else if (in_valid) begin
            // Reads the pre-write word when cfg_we hits the same address.
            out_valid <= 1'b1;
            out_addr  <= in_data;
            out_data  <= tbl[in_data];
          end else begin
            out_valid <= 1'b0;
          end
        end
        SWEEP: begin
          out_valid <= 1'b1;
          out_addr  <= cnt;
          out_data  <= tbl[cnt];
          csum      <= csum + CSUM_W'(tbl[cnt]);
          cnt       <= cnt + N_IN'(1);
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_boolean_lut_sweep.sv
// Directed bench for boolean_lut_sweep; a second instance with CSUM_W=4 shares
// the inputs to exercise checksum wrap.
module tb_boolean_lut_sweep;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_data;
  logic       in_valid;
  logic [3:0] in_data;
  logic       start;

  logic       out_valid, busy, done;
  logic [3:0] out_addr;
  logic [1:0] out_data;
  logic [7:0] csum;

  logic       out_valid_4, busy_4, done_4;
  logic [3:0] out_addr_4;
  logic [1:0] out_data_4;
  logic [3:0] csum_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  boolean_lut_sweep #(.N_IN(4), .N_OUT(2), .CSUM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_data(in_data), .start(start),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .csum(csum)
  );

  boolean_lut_sweep #(.N_IN(4), .N_OUT(2), .CSUM_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_data(in_data), .start(start),
    .out_valid(out_valid_4), .out_addr(out_addr_4), .out_data(out_data_4),
    .busy(busy_4), .done(done_4), .csum(csum_4)
  );

  // Advance past one rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; start = 1'b0;
    #12;
    if ({out_valid, out_addr, out_data, busy, done, csum} !== 17'd0) begin
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_addr, out_data, busy, done, csum});
      n_fail++;
    end
    n_checks++;
    tick();
    rst_n = 1'b1;
    write_word(4'd6, 2'b10);
    in_valid = 1'b1; in_data = 4'd6;
    tick();
    if ({out_valid, out_addr, out_data} !== {1'b1, 4'd6, 2'b10}) begin
      $display("FAIL pre_reset_eval: got %b want %b", {out_valid, out_addr, out_data}, {1'b1, 4'd6, 2'b10});
      n_fail++;
    end
    n_checks++;
    #3 rst_n = 1'b0;
    #1;
    if ({out_valid, out_addr, out_data, busy, done, csum} !== 17'd0) begin
      $display("FAIL async_reset_outputs: got %h want 0", {out_valid, out_addr, out_data, busy, done, csum});
      n_fail++;
    end
    n_checks++;
    tick();
    rst_n = 1'b1;
    tick();
    if ({out_valid, out_addr, out_data} !== {1'b1, 4'd6, 2'b00}) begin
      $display("FAIL table_cleared_eval: got %b want %b", {out_valid, out_addr, out_data}, {1'b1, 4'd6, 2'b00});
      n_fail++;
    end
    n_checks++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_evaluate();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      write_word(v, {v[3] & v[2], v[1] | v[0]});
    end
    in_valid = 1'b1; in_data = 4'b1101;
    tick();
    if ({out_valid, out_addr, out_data} !== {1'b1, 4'b1101, 2'b11}) begin
      $display("FAIL eval_1101: got %b want %b", {out_valid, out_addr, out_data}, {1'b1, 4'b1101, 2'b11});
      n_fail++;
    end
    n_checks++;
    in_data = 4'b0010;
    tick();
    if ({out_valid, out_addr, out_data} !== {1'b1, 4'b0010, 2'b01}) begin
      $display("FAIL eval_0010: got %b want %b", {out_valid, out_addr, out_data}, {1'b1, 4'b0010, 2'b01});
      n_fail++;
    end
    n_checks++;
    in_valid = 1'b0; in_data = 4'b1111;
    tick();
    if ({out_valid, out_addr, out_data} !== {1'b0, 4'b0010, 2'b01}) begin
      $display("FAIL eval_idle_hold: got %b want %b", {out_valid, out_addr, out_data}, {1'b0, 4'b0010, 2'b01});
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_sweep_mod4();
    for (int i = 0; i < 16; i++) write_word(4'(i), 2'(i % 4));
    start = 1'b1;
    tick();
    start = 1'b0;
    if ({busy, done, out_valid, csum} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL sweep_start: got %b want %b", {busy, done, out_valid, csum}, {1'b1, 1'b0, 1'b0, 8'd0});
      n_fail++;
    end
    n_checks++;
    for (int j = 0; j < 16; j++) begin
      tick();
      if ({out_valid, out_addr, out_data, busy, done} !== {1'b1, 4'(j), 2'(j % 4), 1'b1, 1'b0}) begin
        $display("FAIL sweep_word_%0d: got %b want %b", j, {out_valid, out_addr, out_data, busy, done},
                 {1'b1, 4'(j), 2'(j % 4), 1'b1, 1'b0});
        n_fail++;
      end
      n_checks++;
    end
    tick();
    if ({done, out_valid, busy, csum, csum_4} !== {1'b1, 1'b0, 1'b1, 8'd24, 4'd8}) begin
      $display("FAIL sweep_done: got %b want %b", {done, out_valid, busy, csum, csum_4},
               {1'b1, 1'b0, 1'b1, 8'd24, 4'd8});
      n_fail++;
    end
    n_checks++;
    tick();
    if ({done, busy, csum} !== {1'b0, 1'b0, 8'd24}) begin
      $display("FAIL sweep_after_done: got %b want %b", {done, busy, csum}, {1'b0, 1'b0, 8'd24});
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_csum_wrap();
    for (int i = 0; i < 16; i++) write_word(4'(i), 2'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      if ({out_addr_4, out_data_4} !== {4'(j), 2'b11}) begin
        $display("FAIL wrap_word_%0d: got %b want %b", j, {out_addr_4, out_data_4}, {4'(j), 2'b11});
        n_fail++;
      end
      n_checks++;
    end
    tick();
    if ({done_4, csum_4, csum} !== {1'b1, 4'd0, 8'd48}) begin
      $display("FAIL csum_wrap: got %b want %b", {done_4, csum_4, csum}, {1'b1, 4'd0, 8'd48});
      n_fail++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_same_cycle_rw();
    write_word(4'd5, 2'b01);
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 2'b10;
    in_valid = 1'b1; in_data = 4'd5;
    tick();
    cfg_we = 1'b0;
    if ({out_valid, out_data} !== {1'b1, 2'b01}) begin
      $display("FAIL rw_old_word: got %b want %b", {out_valid, out_data}, {1'b1, 2'b01});
      n_fail++;
    end
    n_checks++;
    tick();
    in_valid = 1'b0;
    if ({out_valid, out_data} !== {1'b1, 2'b10}) begin
      $display("FAIL rw_new_word: got %b want %b", {out_valid, out_data}, {1'b1, 2'b10});
      n_fail++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_sweep_abort();
    logic [7:0] exp_csum;
    logic [1:0] exp_w;
    // Table here: every word 2'b11 except word 5 = 2'b10.
    exp_csum = 8'd0;
    start = 1'b1;
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 2'b00;
    in_valid = 1'b1; in_data = 4'd3;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_w = (j == 5) ? 2'b10 : 2'b11;
      exp_csum = exp_csum + 8'(exp_w);
      if ({out_valid, out_addr, out_data, busy, done} !== {1'b1, 4'(j), exp_w, 1'b1, 1'b0}) begin
        $display("FAIL abort_word_%0d: got %b want %b", j, {out_valid, out_addr, out_data, busy, done},
                 {1'b1, 4'(j), exp_w, 1'b1, 1'b0});
        n_fail++;
      end
      n_checks++;
    end
    if (csum !== exp_csum) begin
      $display("FAIL abort_partial_csum: got %0d want %0d", csum, exp_csum);
      n_fail++;
    end
    n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if ({out_valid, busy, done, csum} !== 11'd0) begin
      $display("FAIL abort_reset_outputs: got %b want 0", {out_valid, busy, done, csum});
      n_fail++;
    end
    n_checks++;
    start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if ({done, busy, out_valid} !== 3'b000) begin
        $display("FAIL abort_idle_%0d: got %b want 000", j, {done, busy, out_valid});
        n_fail++;
      end
      n_checks++;
    end
    in_valid = 1'b1; in_data = 4'd7;
    tick();
    in_valid = 1'b0;
    if ({out_valid, out_addr, out_data} !== {1'b1, 4'd7, 2'b00}) begin
      $display("FAIL abort_table_cleared: got %b want %b", {out_valid, out_addr, out_data}, {1'b1, 4'd7, 2'b00});
      n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_evaluate();
    test_sweep_mod4();
    test_csum_wrap();
    test_same_cycle_rw();
    test_sweep_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
